// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the three-master bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn  = 2'd1,
    StTurn = 2'd2
  } state_e;

  // Owner codes double as the o_grant encoding.
  typedef enum logic [1:0] {
    OwnM0   = 2'd0,
    OwnM1   = 2'd1,
    OwnM2   = 2'd2,
    OwnNone = 2'd3
  } owner_e;

  localparam int unsigned DefTimeoutCycles = 255;
  localparam int unsigned DefStarveLimit   = 4;

endpackage

// File: rtl/bus_arbiter_prio.sv
// Combinational winner select: fixed m0 > m1 > m2, except that a starved m2 wins outright.
module bus_arbiter_prio
  import bus_arbiter_pkg::*;
(
  input  logic   m0_req,
  input  logic   m1_req,
  input  logic   m2_req,
  input  logic   starve,
  output owner_e winner
);

  // Priority encode the requests, with the starve override on top.
  always_comb begin
    winner = OwnNone;
    if (m2_req && starve) begin
      winner = OwnM2;
    end else if (m0_req) begin
      winner = OwnM0;
    end else if (m1_req) begin
      winner = OwnM1;
    end else if (m2_req) begin
      winner = OwnM2;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Three-master bus arbiter (video m0, uart m1, cpu m2) with a one-cycle turnaround between owners.
// Optional bus timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned STARVE_LIMIT   = DefStarveLimit
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_m0_addr,
  input  logic        i_m0_cs,
  output logic        o_m0_ack,
  input  logic [15:0] i_m1_addr,
  input  logic [7:0]  i_m1_dat,
  input  logic        i_m1_we,
  input  logic        i_m1_cs,
  output logic        o_m1_ack,
  input  logic [15:0] i_m2_addr,
  input  logic [7:0]  i_m2_dat,
  input  logic        i_m2_we,
  input  logic        i_m2_cs,
  output logic        o_m2_ack,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dat,
  output logic        o_we,
  output logic        o_cs,
  input  logic        i_ack,
  output logic [1:0]  o_grant,
  output logic        o_err
);

  localparam int unsigned StarveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  owner_e               winner;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic                 starve_hit;
  logic                 err_q, err_d;
  logic                 owner_cs;
  logic                 tmo_hit;

  assign starve_hit = (starve_q == StarveW'(STARVE_LIMIT));

  bus_arbiter_prio u_prio (
    .m0_req (i_m0_cs),
    .m1_req (i_m1_cs),
    .m2_req (i_m2_cs),
    .starve (starve_hit),
    .winner (winner)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  // tmo_q holds the number of completed OWN cycles; the hit fires in the last allowed one.
  assign tmo_hit = (state_q == StOwn) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Count OWN cycles; held at zero elsewhere so every entry to OWN starts fresh.
  always_comb begin
    tmo_d = '0;
    if (state_q == StOwn) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) | err_q;
  assign o_err              = 1'b0;
`endif

  // Next state: grant from IDLE, release on ack / cs drop / timeout, single turnaround cycle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (winner != OwnNone) begin
          state_d = StOwn;
          owner_d = winner;
          if (winner == OwnM2) begin
            starve_d = '0;
          end else if (i_m2_cs && !starve_hit) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StOwn: begin
        // Ack beats a simultaneous cs drop; both beat the timeout.
        if (i_ack) begin
          state_d = StTurn;
          owner_d = OwnNone;
        end else if (!owner_cs) begin
          state_d = StIdle;
          owner_d = OwnNone;
        end else if (tmo_hit) begin
          state_d = StTurn;
          owner_d = OwnNone;
          err_d   = 1'b1;
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  // State, owner, starve counter and error pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      owner_q  <= OwnNone;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // Bus mux and ack steering from the registered owner; m0 is read-only.
  always_comb begin
    o_addr   = '0;
    o_dat    = '0;
    o_we     = 1'b0;
    owner_cs = 1'b0;
    o_m0_ack = 1'b0;
    o_m1_ack = 1'b0;
    o_m2_ack = 1'b0;
    o_grant  = OwnNone;
    if (state_q == StOwn) begin
      o_grant = owner_q;
      unique case (owner_q)
        OwnM0: begin
          o_addr   = i_m0_addr;
          owner_cs = i_m0_cs;
          o_m0_ack = i_ack;
        end
        OwnM1: begin
          o_addr   = i_m1_addr;
          o_dat    = i_m1_dat;
          o_we     = i_m1_we;
          owner_cs = i_m1_cs;
          o_m1_ack = i_ack;
        end
        OwnM2: begin
          o_addr   = i_m2_addr;
          o_dat    = i_m2_dat;
          o_we     = i_m2_we;
          owner_cs = i_m2_cs;
          o_m2_ack = i_ack;
        end
        default: begin
          o_grant = OwnNone;
        end
      endcase
    end
  end

  assign o_cs = owner_cs;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; grant order checked through an expected-owner queue.
module tb_bus_arbiter;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] i_m0_addr;
  logic        i_m0_cs;
  logic        o_m0_ack;
  logic [15:0] i_m1_addr;
  logic [7:0]  i_m1_dat;
  logic        i_m1_we;
  logic        i_m1_cs;
  logic        o_m1_ack;
  logic [15:0] i_m2_addr;
  logic [7:0]  i_m2_dat;
  logic        i_m2_we;
  logic        i_m2_cs;
  logic        o_m2_ack;
  logic [15:0] o_addr;
  logic [7:0]  o_dat;
  logic        o_we;
  logic        o_cs;
  logic        i_ack;
  logic [1:0]  o_grant;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  bus_arbiter #(
    .TIMEOUT_CYCLES (8),
    .STARVE_LIMIT   (4)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_m0_addr (i_m0_addr),
    .i_m0_cs   (i_m0_cs),
    .o_m0_ack  (o_m0_ack),
    .i_m1_addr (i_m1_addr),
    .i_m1_dat  (i_m1_dat),
    .i_m1_we   (i_m1_we),
    .i_m1_cs   (i_m1_cs),
    .o_m1_ack  (o_m1_ack),
    .i_m2_addr (i_m2_addr),
    .i_m2_dat  (i_m2_dat),
    .i_m2_we   (i_m2_we),
    .i_m2_cs   (i_m2_cs),
    .o_m2_ack  (o_m2_ack),
    .o_addr    (o_addr),
    .o_dat     (o_dat),
    .o_we      (o_we),
    .o_cs      (o_cs),
    .i_ack     (i_ack),
    .o_grant   (o_grant),
    .o_err     (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant, compare it with the queue head, then ack it on the second cycle.
  task automatic serve_one(input string tag);
    int n;
    int exp_owner;
    n = 0;
    while (o_grant == 2'd3 && n < 20) begin
      tick();
      n++;
    end
    exp_owner = (exp_q.size() > 0) ? exp_q.pop_front() : 3;
    check(tag, 32'(o_grant), exp_owner);
    tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  initial begin
    int n;
    i_reset   = 1'b1;
    i_m0_addr = '0;
    i_m0_cs   = 1'b0;
    i_m1_addr = '0;
    i_m1_dat  = '0;
    i_m1_we   = 1'b0;
    i_m1_cs   = 1'b0;
    i_m2_addr = '0;
    i_m2_dat  = '0;
    i_m2_we   = 1'b0;
    i_m2_cs   = 1'b0;
    i_ack     = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(o_grant), 3);
    check("rst_cs", 32'(o_cs), 0);
    check("rst_err", 32'(o_err), 0);
    check("rst_addr", 32'(o_addr), 0);
    i_reset = 1'b0;

    // m1 and m2 together: m1 first, m2 after turnaround.
    i_m1_addr = 16'h1111; i_m1_dat = 8'hA5; i_m1_we = 1'b1; i_m1_cs = 1'b1;
    i_m2_addr = 16'h2222; i_m2_dat = 8'h3C; i_m2_we = 1'b0; i_m2_cs = 1'b1;
    tick();
    check("m1_grant", 32'(o_grant), 1);
    check("m1_addr", 32'(o_addr), 32'h1111);
    check("m1_we", 32'(o_we), 1);
    check("m1_dat", 32'(o_dat), 32'hA5);
    check("m1_cs", 32'(o_cs), 1);
    check("m1_ack_early", 32'(o_m1_ack), 0);
    i_ack = 1'b1;
    #1;
    check("m1_ack", 32'({o_m0_ack, o_m1_ack, o_m2_ack}), 3'b010);
    tick();
    check("turn_grant", 32'(o_grant), 3);
    check("turn_cs", 32'(o_cs), 0);
    check("turn_ack", 32'({o_m0_ack, o_m1_ack, o_m2_ack}), 0);
    i_ack = 1'b0; i_m1_cs = 1'b0;
    tick();
    check("idle_grant", 32'(o_grant), 3);
    tick();
    check("m2_grant", 32'(o_grant), 2);
    check("m2_addr", 32'(o_addr), 32'h2222);
    check("m2_dat", 32'(o_dat), 32'h3C);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0; i_m2_cs = 1'b0;
    tick();

    // Owner drops cs without ack: straight back to IDLE; stray ack there is ignored.
    i_m1_cs = 1'b1;
    tick();
    check("drop_grant", 32'(o_grant), 1);
    i_m1_cs = 1'b0;
    tick();
    check("drop_idle", 32'(o_grant), 3);
    i_ack = 1'b1;
    #1;
    check("idle_ack", 32'({o_m0_ack, o_m1_ack, o_m2_ack}), 0);
    tick();
    check("idle_ack_grant", 32'(o_grant), 3);
    check("idle_ack_cs", 32'(o_cs), 0);
    i_ack = 1'b0;

    // m2 owns; m0 request must not preempt. m0 then forces we/dat to 0.
    i_m2_addr = 16'h1234; i_m2_dat = 8'h77; i_m2_we = 1'b1; i_m2_cs = 1'b1;
    tick();
    check("pre_grant", 32'(o_grant), 2);
    i_m0_addr = 16'hABCD; i_m0_cs = 1'b1;
    i_m1_dat = 8'hA5; i_m1_we = 1'b1;
    tick();
    tick();
    check("nopreempt_grant", 32'(o_grant), 2);
    check("nopreempt_addr", 32'(o_addr), 32'h1234);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0; i_m2_cs = 1'b0;
    tick();
    tick();
    check("m0_grant", 32'(o_grant), 0);
    check("m0_addr", 32'(o_addr), 32'hABCD);
    check("m0_we", 32'(o_we), 0);
    check("m0_dat", 32'(o_dat), 0);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;

    // Starvation: m0 and m2 both request continuously.
    i_m2_cs = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0);
    for (int i = 0; i < 6; i++) begin
      serve_one("starve_order");
    end

    // Reset mid-OWN; starve count must restart from zero afterwards.
    exp_q.push_back(0);
    n = 0;
    while (o_grant == 2'd3 && n < 20) begin
      tick();
      n++;
    end
    check("pre_reset_grant", 32'(o_grant), exp_q.pop_front());
    tick();
    check("pre_reset_cs", 32'(o_cs), 1);
    i_reset = 1'b1; i_ack = 1'b1;
    tick();
    check("reset_grant", 32'(o_grant), 3);
    check("reset_cs", 32'(o_cs), 0);
    check("reset_addr", 32'(o_addr), 0);
    check("reset_ack", 32'({o_m0_ack, o_m1_ack, o_m2_ack}), 0);
    check("reset_err", 32'(o_err), 0);
    i_reset = 1'b0; i_ack = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(2);
    for (int i = 0; i < 5; i++) begin
      serve_one("post_reset_order");
    end
    i_m0_cs = 1'b0; i_m2_cs = 1'b0;
    tick();
    tick();

    // Stalled m1 with no ack.
    i_m1_cs = 1'b1;
    tick();
    check("stall_grant", 32'(o_grant), 1);
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      check("tmo_err_early", 32'(o_err), 0);
    end
    check("tmo_grant_8", 32'(o_grant), 1);
    tick();
    check("tmo_err", 32'(o_err), 1);
    check("tmo_ack", 32'(o_m1_ack), 0);
    check("tmo_turn", 32'(o_grant), 3);
    i_m1_cs = 1'b0;
    tick();
    check("tmo_err_pulse", 32'(o_err), 0);
`else
    repeat (20) tick();
    check("wait_grant", 32'(o_grant), 1);
    check("wait_err", 32'(o_err), 0);
    i_ack = 1'b1;
    #1;
    check("wait_ack", 32'(o_m1_ack), 1);
    tick();
    i_ack = 1'b0; i_m1_cs = 1'b0;
    tick();
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles allowed per grant before abort (only with the timeout feature, REQ-030).
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive higher-priority grants tolerated while the lowest-priority master waits.
REQ-003 i_clk  in  1  system clock; the block SHALL use one clock only.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_m0_addr  in  16  video master address; m0 is read-only and has highest priority.
REQ-006 i_m0_cs  in  1  video master request.
REQ-007 o_m0_ack  out  1  video master acknowledge.
REQ-008 i_m1_addr / i_m1_dat / i_m1_we / i_m1_cs  in  16/8/1/1  uart master address, write data, write enable and request.
REQ-009 o_m1_ack  out  1  uart master acknowledge.
REQ-010 i_m2_addr / i_m2_dat / i_m2_we / i_m2_cs  in  16/8/1/1  cpu master address, write data, write enable and request.
REQ-011 o_m2_ack  out  1  cpu master acknowledge.
REQ-012 o_addr / o_dat / o_we / o_cs  out  16/8/1/1  shared bus toward memory and slaves.
REQ-013 i_ack  in  1  shared bus acknowledge.
REQ-014 o_grant  out  2  current owner: 0=m0, 1=m1, 2=m2, 3=none.
REQ-015 o_err  out  1  one-cycle pulse on a timeout abort.

Function
REQ-016 States: IDLE, OWN and TURN. The state, owner, counters and o_err SHALL be registered.
REQ-017 In IDLE with any cs high, the block SHALL register a winner at the next edge and enter OWN; o_cs SHALL be high from that cycle. Grant latency is 1 cycle.
REQ-018 Winner selection: m0 > m1 > m2. The exception is REQ-019.
REQ-019 A starve counter SHALL increment on every grant to m0 or m1 while i_m2_cs is high, and clear on any grant to m2. When the counter equals STARVE_LIMIT and i_m2_cs is high, m2 SHALL win.
REQ-020 In OWN, o_addr, o_dat, o_we and o_cs SHALL be driven by the owner. m0 forces o_we=0 and o_dat=0.
REQ-021 When no master owns the bus, o_addr, o_dat, o_we, o_cs SHALL be 0 and o_grant SHALL be 3.
REQ-022 The owner's ack SHALL equal i_ack combinationally. Non-owners' acks SHALL be 0.
REQ-023 i_ack in OWN: next state is TURN. TURN lasts exactly 1 cycle with o_cs=0 and no owner, then returns to IDLE.
REQ-024 Owner drops cs in OWN without i_ack: the block SHALL return to IDLE next cycle, with no ack and no starve update.
REQ-025 A higher-priority request during OWN SHALL NOT preempt the owner.
REQ-026 Simultaneous i_ack and owner cs drop: i_ack wins (TURN).
REQ-027 i_ack outside OWN SHALL be ignored.

Reset
REQ-028 i_reset at any cycle, including mid-transaction, SHALL force the following at the next edge:
- state IDLE, o_grant=3;
- o_cs, o_we, o_addr, o_dat, o_err and all acks 0;
- starve and timeout counters 0.

Configuration
REQ-029 Macro BUS_ARBITER_TIMEOUT_EN enables the timeout feature.
REQ-030 With BUS_ARBITER_TIMEOUT_EN defined:
- a counter SHALL count OWN cycles;
- when it reaches TIMEOUT_CYCLES without i_ack, the block SHALL pulse o_err, give no ack and enter TURN;
- the counter SHALL clear on every entry to OWN.
REQ-031 Without BUS_ARBITER_TIMEOUT_EN: no timeout counter; o_err is tied 0; OWN waits indefinitely.

Structure
REQ-032 A shared package SHALL hold the state encoding, the owner codes (M0=0, M1=1, M2=2, NONE=3) and the default parameter constants.
REQ-033 Sub-module bus_arbiter_prio SHALL implement the combinational winner select (requests, starve flag -> owner code). The FSM, counters and bus mux remain in bus_arbiter.

Verification
REQ-034 m1 and m2 cs high together in IDLE -> o_grant=1 the next cycle, o_addr=i_m1_addr. After i_ack: o_m1_ack=1 for 1 cycle, TURN, then o_grant=2.
REQ-035 m0 and m2 requesting continuously with STARVE_LIMIT=4 and i_ack 2 cycles after each grant -> grant order m0,m0,m0,m0,m2,m0...
REQ-036 m2 owns the bus (addr 16'h1234) and m0 raises cs -> o_grant stays 2 until i_ack; m0 is granted after TURN.
REQ-037 i_reset asserted mid-OWN with o_cs=1 -> next cycle o_cs=0, o_grant=3, all acks 0. The starve counter restarts from 0.
REQ-038 BUS_ARBITER_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, m1 granted, no i_ack -> o_err=1 for exactly 1 cycle after 8 OWN cycles; o_m1_ack stays 0.
REQ-039 m1 owns the bus with i_m1_we=1 and i_m1_dat=8'hA5 -> o_we=1, o_dat=8'hA5. A subsequent m0 grant drives o_we=0, o_dat=0.
